// File: rtl/axi_xbar_nslv.sv
// Purpose: 1-master to N_SLV-slave AXI4 demux; decodes AR/AW once per burst, routes the whole burst, DECERR for unmapped.
// Latency: 1 cycle from upstream AR/AW handshake to downstream valid; data/response beats pass through with zero added latency.
// Backpressure: one outstanding read and one outstanding write; arready/awready low outside IDLE, beats follow the selected slave's ready.
//
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_axi_ar*/o_axi_r*       upstream read address / read data
//   i_axi_aw*/i_axi_w*/o_axi_b*  upstream write address / write data / write response
//   o_s_*/i_s_*              downstream channels, N_SLV slots packed, slot 0 in the LSBs
module axi_xbar_nslv #(
    parameter int N_SLV  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h0200_0000, 32'hA000_03F8, 32'h8000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_FFF8, 32'hF000_0000}
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    // upstream AR
    input  logic [ADDR_W-1:0]           i_axi_araddr,
    input  logic                        i_axi_arvalid,
    input  logic [ID_W-1:0]             i_axi_arid,
    input  logic [7:0]                  i_axi_arlen,
    input  logic [2:0]                  i_axi_arsize,
    input  logic [1:0]                  i_axi_arburst,
    output logic                        o_axi_arready,
    // upstream R
    output logic [DATA_W-1:0]           o_axi_rdata,
    output logic                        o_axi_rvalid,
    output logic [1:0]                  o_axi_rresp,
    output logic [ID_W-1:0]             o_axi_rid,
    output logic                        o_axi_rlast,
    input  logic                        i_axi_rready,
    // upstream AW
    input  logic [ADDR_W-1:0]           i_axi_awaddr,
    input  logic                        i_axi_awvalid,
    input  logic [ID_W-1:0]             i_axi_awid,
    input  logic [7:0]                  i_axi_awlen,
    input  logic [2:0]                  i_axi_awsize,
    input  logic [1:0]                  i_axi_awburst,
    output logic                        o_axi_awready,
    // upstream W
    input  logic [DATA_W-1:0]           i_axi_wdata,
    input  logic [DATA_W/8-1:0]         i_axi_wstrb,
    input  logic                        i_axi_wvalid,
    input  logic                        i_axi_wlast,
    output logic                        o_axi_wready,
    // upstream B
    output logic [1:0]                  o_axi_bresp,
    output logic                        o_axi_bvalid,
    output logic [ID_W-1:0]             o_axi_bid,
    input  logic                        i_axi_bready,
    // downstream AR
    output logic [N_SLV*ADDR_W-1:0]     o_s_araddr,
    output logic [N_SLV-1:0]            o_s_arvalid,
    output logic [N_SLV*ID_W-1:0]       o_s_arid,
    output logic [N_SLV*8-1:0]          o_s_arlen,
    output logic [N_SLV*3-1:0]          o_s_arsize,
    output logic [N_SLV*2-1:0]          o_s_arburst,
    input  logic [N_SLV-1:0]            i_s_arready,
    // downstream R
    input  logic [N_SLV*DATA_W-1:0]     i_s_rdata,
    input  logic [N_SLV-1:0]            i_s_rvalid,
    input  logic [N_SLV*2-1:0]          i_s_rresp,
    input  logic [N_SLV*ID_W-1:0]       i_s_rid,
    input  logic [N_SLV-1:0]            i_s_rlast,
    output logic [N_SLV-1:0]            o_s_rready,
    // downstream AW
    output logic [N_SLV*ADDR_W-1:0]     o_s_awaddr,
    output logic [N_SLV-1:0]            o_s_awvalid,
    output logic [N_SLV*ID_W-1:0]       o_s_awid,
    output logic [N_SLV*8-1:0]          o_s_awlen,
    output logic [N_SLV*3-1:0]          o_s_awsize,
    output logic [N_SLV*2-1:0]          o_s_awburst,
    input  logic [N_SLV-1:0]            i_s_awready,
    // downstream W
    output logic [N_SLV*DATA_W-1:0]     o_s_wdata,
    output logic [N_SLV*DATA_W/8-1:0]   o_s_wstrb,
    output logic [N_SLV-1:0]            o_s_wvalid,
    output logic [N_SLV-1:0]            o_s_wlast,
    input  logic [N_SLV-1:0]            i_s_wready,
    // downstream B
    input  logic [N_SLV*2-1:0]          i_s_bresp,
    input  logic [N_SLV-1:0]            i_s_bvalid,
    input  logic [N_SLV*ID_W-1:0]       i_s_bid,
    output logic [N_SLV-1:0]            o_s_bready
);

    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int SB = DATA_W / 8;

    // Returns {hit, index}; scanning downwards lets the lowest matching slot win.
    function automatic logic [SW:0] decode(input logic [ADDR_W-1:0] a);
        logic [SW:0] res;
        res = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((a & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                res = {1'b1, SW'(k)};
            end
        end
        return res;
    endfunction

    logic [SW:0] ar_dec;
    logic [SW:0] aw_dec;
    assign ar_dec = decode(i_axi_araddr);
    assign aw_dec = decode(i_axi_awaddr);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;

    r_state_t          r_state, r_state_nxt;
    logic [SW-1:0]     r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= R_IDLE;
            r_sel   <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && i_axi_arvalid) begin
                r_sel   <= ar_dec[SW-1:0];
                r_addr  <= i_axi_araddr;
                r_id    <= i_axi_arid;
                r_len   <= i_axi_arlen;
                r_size  <= i_axi_arsize;
                r_burst <= i_axi_arburst;
                r_cnt   <= '0;
            end else if (r_state == R_ERR && i_axi_rready) begin
                // Leaves R_ERR on cnt==len, so 8 bits never need to wrap.
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        r_state_nxt   = r_state;
        o_axi_arready = 1'b0;
        o_axi_rdata   = '0;
        o_axi_rvalid  = 1'b0;
        o_axi_rresp   = '0;
        o_axi_rid     = '0;
        o_axi_rlast   = 1'b0;
        o_s_araddr    = '0;
        o_s_arvalid   = '0;
        o_s_arid      = '0;
        o_s_arlen     = '0;
        o_s_arsize    = '0;
        o_s_arburst   = '0;
        o_s_rready    = '0;
        // Everything is held at zero for the whole reset cycle, whatever the state.
        if (!i_reset) begin
            unique case (r_state)
                R_IDLE: begin
                    o_axi_arready = 1'b1;
                    if (i_axi_arvalid) begin
                        r_state_nxt = ar_dec[SW] ? R_ADDR : R_ERR;
                    end
                end
                R_ADDR: begin
                    for (int k = 0; k < N_SLV; k++) begin
                        if (SW'(k) == r_sel) begin
                            o_s_arvalid[k]                 = 1'b1;
                            o_s_araddr[k*ADDR_W +: ADDR_W] = r_addr;
                            o_s_arid[k*ID_W +: ID_W]       = r_id;
                            o_s_arlen[k*8 +: 8]            = r_len;
                            o_s_arsize[k*3 +: 3]           = r_size;
                            o_s_arburst[k*2 +: 2]          = r_burst;
                            if (i_s_arready[k]) begin
                                r_state_nxt = R_DATA;
                            end
                        end
                    end
                end
                R_DATA: begin
                    for (int k = 0; k < N_SLV; k++) begin
                        if (SW'(k) == r_sel) begin
                            o_axi_rvalid  = i_s_rvalid[k];
                            o_axi_rdata   = i_s_rdata[k*DATA_W +: DATA_W];
                            o_axi_rresp   = i_s_rresp[k*2 +: 2];
                            o_axi_rid     = i_s_rid[k*ID_W +: ID_W];
                            o_axi_rlast   = i_s_rlast[k];
                            o_s_rready[k] = i_axi_rready;
                            if (i_s_rvalid[k] && i_axi_rready && i_s_rlast[k]) begin
                                r_state_nxt = R_IDLE;
                            end
                        end
                    end
                end
                R_ERR: begin
                    o_axi_rvalid = 1'b1;
                    o_axi_rresp  = 2'b11;
                    o_axi_rid    = r_id;
                    o_axi_rlast  = (r_cnt == r_len);
                    if (i_axi_rready && (r_cnt == r_len)) begin
                        r_state_nxt = R_IDLE;
                    end
                end
                default: r_state_nxt = R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR, W_ERESP} w_state_t;

    w_state_t          w_state, w_state_nxt;
    logic [SW-1:0]     w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            w_state <= W_IDLE;
            w_sel   <= '0;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (w_state == W_IDLE && i_axi_awvalid) begin
                w_sel   <= aw_dec[SW-1:0];
                w_addr  <= i_axi_awaddr;
                w_id    <= i_axi_awid;
                w_len   <= i_axi_awlen;
                w_size  <= i_axi_awsize;
                w_burst <= i_axi_awburst;
            end
        end
    end

    always_comb begin
        w_state_nxt   = w_state;
        o_axi_awready = 1'b0;
        o_axi_wready  = 1'b0;
        o_axi_bresp   = '0;
        o_axi_bvalid  = 1'b0;
        o_axi_bid     = '0;
        o_s_awaddr    = '0;
        o_s_awvalid   = '0;
        o_s_awid      = '0;
        o_s_awlen     = '0;
        o_s_awsize    = '0;
        o_s_awburst   = '0;
        o_s_wdata     = '0;
        o_s_wstrb     = '0;
        o_s_wvalid    = '0;
        o_s_wlast     = '0;
        o_s_bready    = '0;
        if (!i_reset) begin
            unique case (w_state)
                W_IDLE: begin
                    o_axi_awready = 1'b1;
                    if (i_axi_awvalid) begin
                        w_state_nxt = aw_dec[SW] ? W_ADDR : W_ERR;
                    end
                end
                W_ADDR: begin
                    for (int k = 0; k < N_SLV; k++) begin
                        if (SW'(k) == w_sel) begin
                            o_s_awvalid[k]                 = 1'b1;
                            o_s_awaddr[k*ADDR_W +: ADDR_W] = w_addr;
                            o_s_awid[k*ID_W +: ID_W]       = w_id;
                            o_s_awlen[k*8 +: 8]            = w_len;
                            o_s_awsize[k*3 +: 3]           = w_size;
                            o_s_awburst[k*2 +: 2]          = w_burst;
                            if (i_s_awready[k]) begin
                                w_state_nxt = W_DATA;
                            end
                        end
                    end
                end
                W_DATA: begin
                    for (int k = 0; k < N_SLV; k++) begin
                        if (SW'(k) == w_sel) begin
                            o_s_wvalid[k]                 = i_axi_wvalid;
                            o_s_wdata[k*DATA_W +: DATA_W] = i_axi_wdata;
                            o_s_wstrb[k*SB +: SB]         = i_axi_wstrb;
                            o_s_wlast[k]                  = i_axi_wlast;
                            o_axi_wready                  = i_s_wready[k];
                            if (i_axi_wvalid && i_s_wready[k] && i_axi_wlast) begin
                                w_state_nxt = W_RESP;
                            end
                        end
                    end
                end
                W_RESP: begin
                    for (int k = 0; k < N_SLV; k++) begin
                        if (SW'(k) == w_sel) begin
                            o_axi_bvalid  = i_s_bvalid[k];
                            o_axi_bresp   = i_s_bresp[k*2 +: 2];
                            o_axi_bid     = i_s_bid[k*ID_W +: ID_W];
                            o_s_bready[k] = i_axi_bready;
                            if (i_s_bvalid[k] && i_axi_bready) begin
                                w_state_nxt = W_IDLE;
                            end
                        end
                    end
                end
                W_ERR: begin
                    // Sink the burst so the master can finish; data is dropped.
                    o_axi_wready = 1'b1;
                    if (i_axi_wvalid && i_axi_wlast) begin
                        w_state_nxt = W_ERESP;
                    end
                end
                W_ERESP: begin
                    o_axi_bvalid = 1'b1;
                    o_axi_bresp  = 2'b11;
                    o_axi_bid    = w_id;
                    if (i_axi_bready) begin
                        w_state_nxt = W_IDLE;
                    end
                end
                default: w_state_nxt = W_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_xbar_nslv.md
Name: axi_xbar_nslv

Overview:
- Parametrised 1-master to N-slave AXI4 crossbar (demux) between the core's LSU/IFU arbiter and the memory/peripheral slaves (SRAM, UART, CLINT, ...).
- Decodes each AR/AW address once, registers the target and the request fields, then routes the full burst to that slave.
- Unmapped addresses get an AXI DECERR response generated inside the block.
- Read and write paths are independent FSMs; each allows one outstanding transaction.

Parameters:
N_SLV, 3, number of downstream slaves
ADDR_W, 32, address width
DATA_W, 32, data width (strobe width DATA_W/8)
ID_W, 4, AXI ID width
SLV_BASE, {32'h0200_0000, 32'hA000_03F8, 32'h8000_0000}, packed N_SLV*ADDR_W region bases (slot 0 = LSBs)
SLV_MASK, {32'hFFFF_0000, 32'hFFFF_FFF8, 32'hF000_0000}, packed region masks

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_axi_ar{addr,valid,id,len,size,burst}  in  ADDR_W/1/ID_W/8/3/2  upstream AR; o_axi_arready out 1
o_axi_r{data,valid,resp,id,last}  out  DATA_W/1/2/ID_W/1  upstream R; i_axi_rready in 1
i_axi_aw{addr,valid,id,len,size,burst}  in  ADDR_W/1/ID_W/8/3/2  upstream AW; o_axi_awready out 1
i_axi_w{data,strb,valid,last}  in  DATA_W/DATA_W/8/1/1  upstream W; o_axi_wready out 1
o_axi_b{resp,valid,id}  out  2/1/ID_W  upstream B; i_axi_bready in 1
o_s_ar{addr,valid,id,len,size,burst}  out  N_SLV x field width, packed  downstream AR; i_s_arready in N_SLV
i_s_r{data,valid,resp,id,last}  in  N_SLV x field width, packed  downstream R; o_s_rready out N_SLV
o_s_aw{...}, o_s_w{...}, o_s_bready / i_s_awready, i_s_wready, i_s_b{resp,valid,id}  same packing for write channels

Behaviour:
- Reset (synchronous, i_reset high): both FSMs go to IDLE. All ready/valid outputs are 0 while i_reset is high. All downstream payload outputs are 0. Reset mid-burst abandons the transaction without completing it.
- Decode: hit[k] = ((addr & MASK[k]) == BASE[k]). The lowest k among hits wins. No hit = unmapped.
- Unselected slaves see all outputs 0.
- Read FSM:
  - R_IDLE: o_axi_arready=1. On arvalid&arready, latch addr/id/len/size/burst and the decoded sel. Go to R_ADDR if mapped, else R_ERR with beat counter=0.
  - R_ADDR: o_s_arvalid[sel]=1 with the latched fields. On i_s_arready[sel], go to R_DATA.
  - R_DATA: R channel is combinationally passed through from sel; o_s_rready[sel]=i_axi_rready. On a handshake with rlast, go to R_IDLE.
  - R_ERR: rvalid=1, rdata=0, rresp=2'b11, rid=latched id, rlast=(cnt==len). cnt increments on each handshake. The handshake with rlast returns to R_IDLE. A response always carries len+1 beats.
- Write FSM:
  - W_IDLE: awready=1. Latch AW fields and sel. Go to W_ADDR if mapped, else W_ERR.
  - W_ADDR: o_s_awvalid[sel]=1. On awready, go to W_DATA. Upstream wready=0.
  - W_DATA: W is passed through to sel. A handshake with wlast goes to W_RESP.
  - W_RESP: B is passed through from sel. bvalid&bready returns to W_IDLE.
  - W_ERR: wready=1; beats are discarded. A handshake with wlast goes to W_ERESP.
  - W_ERESP: bvalid=1, bresp=2'b11, bid=latched id. On bready, go to W_IDLE.
- Latency: 1 cycle from upstream AR/AW handshake to downstream valid. Data beats have zero added latency.
- Read and write FSMs run concurrently with no ordering between them. They may target the same slave simultaneously.
- Upstream arready/awready are low outside IDLE (back-pressure, one outstanding per direction).
- len=0 is a single beat. len=255 must count without wrap (counter is 8 bits, compared to len).

Test Plan:
- AR addr 0x8000_0010 len 3 → s0 arvalid 1 cycle after handshake with latched fields. Slave returns 4 beats D0..D3, rlast on D3 → passed through unchanged, arready back to 1 the cycle after the last handshake.
- AR 0xA000_03FC → s1 selected (mask 0xFFFF_FFF8 hit). AR 0x0200_0004 → s2. Other slaves' arvalid stay 0.
- AR 0x4000_0000 len 2 id 5 → 3 beats rdata 0, rresp 2'b11, rid 5, rlast on third. rready held low 2 cycles mid-burst → rvalid/data held, cnt unchanged.
- AW 0x1000_0000 id 3 + 2 W beats (wlast on 2nd) → both beats accepted, then bvalid with bresp 2'b11, bid 3. No downstream awvalid/wvalid.
- Concurrent read to s0 and write to s1 on the same cycle → both complete independently. A second AR during R_DATA sees arready=0 until the first burst ends.
- i_reset asserted in R_DATA beat 2 → next cycle all valids 0, arready 1 after reset deasserts, new AR decoded correctly.
